// File: rtl/count_slot_sched_pkg.sv
// ---------------------------------------------------------------------------
// count_slot_sched_pkg : shared types and defaults for the counter slot scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package count_slot_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;
    localparam int CNT_MAX  = (1 << W_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/count_slot_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational wrap-around priority search starting at ptr_i
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    // Scan from the farthest offset down so the nearest requester at or after
    // ptr_i is the last one written and therefore wins.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                idx_o = IW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_slot_sched.sv
// ---------------------------------------------------------------------------
// count_slot_sched : round-robin time-sharing of one external loadable counter.
// Optional macro SLOT_ABORT_EN: dropping req of the granted slot aborts it.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module count_slot_sched
    import count_slot_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_value,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              ctr_load,
    output logic [W-1:0]      ctr_load_data,
    input  logic [W-1:0]      ctr_count
);

    localparam int            IW    = $clog2(NREQ);
    localparam logic [W-1:0]  C_MAX = {W{1'b1}};

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    val_q, val_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr_next;
    logic [NREQ-1:0] idx_onehot;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign ptr_next = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LOAD;
                    idx_d   = pick_idx;
                    val_d   = req_value[pick_idx*W +: W];
                end
            end
            LOAD:    state_d = RUN;
            RUN: begin
                if (ctr_count == C_MAX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = ptr_next;
            end
            default: state_d = IDLE;
        endcase
`ifdef SLOT_ABORT_EN
        // Abandon the slot without a done pulse once its owner lets go.
        if ((state_q == LOAD || state_q == RUN) && !req[idx_q]) begin
            state_d = IDLE;
            ptr_d   = ptr_next;
        end
`endif
    end

    assign idx_onehot    = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
    assign gnt           = (state_q == LOAD || state_q == RUN) ? idx_onehot : '0;
    assign done          = (state_q == DONE) ? idx_onehot : '0;
    assign busy          = (state_q != IDLE);
    assign ctr_load      = (state_q == LOAD);
    assign ctr_load_data = val_q;

endmodule

`default_nettype wire

// File: tb/tb_count_slot_sched.sv
// ---------------------------------------------------------------------------
// tb_count_slot_sched : self-checking bench for count_slot_sched with a
// behavioural model of the external free-running loadable counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_count_slot_sched;

    localparam int N  = 4;
    localparam int WW = 4;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic [N-1:0]      req       = '0;
    logic [N*WW-1:0]   req_value = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic              busy;
    logic              ctr_load;
    logic [WW-1:0]     ctr_load_data;
    logic [WW-1:0]     cnt = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]  mask;
        logic [WW-1:0] v;
        logic [N-1:0]  exp_gnt;
        int            exp_run;
    } vec_t;

    vec_t tbl[6];

    count_slot_sched #(
        .NREQ (N),
        .W    (WW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_value     (req_value),
        .gnt           (gnt),
        .done          (done),
        .busy          (busy),
        .ctr_load      (ctr_load),
        .ctr_load_data (ctr_load_data),
        .ctr_count     (cnt)
    );

    always #5 clk = ~clk;

    // External counter: loads on strobe, otherwise counts up and wraps.
    always @(posedge clk) cnt <= ctr_load ? ctr_load_data : cnt + 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req     = '0;
        reset_n = 1'b0;
        #1 chk("rst_outputs", 32'({gnt, done, busy, ctr_load, ctr_load_data}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic run_slot(input logic [N-1:0] mask, input logic [WW-1:0] v,
                            input logic [N-1:0] exp_gnt, input int exp_run);
        int run;
        @(negedge clk);
        req       = mask;
        req_value = {N{v}};
        @(negedge clk);
        chk("load_gnt", 32'(gnt), 32'(exp_gnt));
        chk("load_strobe", 32'(ctr_load), 32'd1);
        chk("load_data", 32'(ctr_load_data), 32'(v));
        chk("load_busy", 32'(busy), 32'd1);
        run = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done != '0) break;
            chk("run_gnt", 32'({gnt, ctr_load}), 32'({exp_gnt, 1'b0}));
            run++;
        end
        chk("run_len", 32'(run), 32'(exp_run));
        chk("done_id", 32'(done), 32'(exp_gnt));
        chk("done_gnt", 32'(gnt), 32'd0);
        req = '0;
        @(negedge clk);
        chk("after_done", 32'({busy, done}), 32'd0);
    endtask

    task automatic round_robin();
        int ld_cyc[5];
        int ld_g[5];
        int dn_cyc[5];
        int dn_g[5];
        int exp_o[5];
        int nl;
        int nd;
        exp_o = '{1, 2, 4, 8, 1};
        nl = 0;
        nd = 0;
        do_reset();
        req_value = {N{4'hF}};
        req       = '1;
        for (int c = 0; c < 60 && nl < 5; c++) begin
            @(negedge clk);
            if (ctr_load) begin ld_cyc[nl] = c; ld_g[nl] = int'(gnt); nl++; end
            if (done != '0 && nd < 5) begin dn_cyc[nd] = c; dn_g[nd] = int'(done); nd++; end
        end
        chk("rr_loads", 32'(nl), 32'd5);
        chk("rr_dones", 32'(nd), 32'd4);
        for (int i = 0; i < nl; i++) chk("rr_order", 32'(ld_g[i]), 32'(exp_o[i]));
        for (int i = 0; i < nd && i < 4; i++) begin
            chk("rr_done_id", 32'(dn_g[i]), 32'(exp_o[i]));
            chk("rr_load_to_done", 32'(dn_cyc[i] - ld_cyc[i]), 32'd2);
            if (i + 1 < nl) chk("rr_done_to_load", 32'(ld_cyc[i+1] - dn_cyc[i]), 32'd2);
        end
        req = '0;
        wait_idle("rr_idle");
    endtask

    task automatic drop_or_abort();
`ifdef SLOT_ABORT_EN
        do_reset();
        @(negedge clk);
        req       = 4'b1000;
        req_value = {N{4'h5}};
        @(negedge clk);
        chk("ab_load_gnt", 32'(gnt), 32'h8);
        req = 4'b1001;
        @(negedge clk);
        chk("ab_run_gnt", 32'(gnt), 32'h8);
        req = 4'b0001;
        @(negedge clk);
        chk("ab_idle", 32'({gnt, done, busy}), 32'd0);
        @(negedge clk);
        chk("ab_next_gnt", 32'({gnt, ctr_load}), 32'({4'b0001, 1'b1}));
        req = '0;
        wait_idle("ab_final_idle");
`else
        int run;
        do_reset();
        @(negedge clk);
        req       = 4'b0010;
        req_value = {N{4'h8}};
        @(negedge clk);
        chk("drop_load_gnt", 32'(gnt), 32'h2);
        run = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done != '0) break;
            run++;
            if (run == 2) req = '0;
        end
        chk("drop_run_len", 32'(run), 32'd8);
        chk("drop_done", 32'(done), 32'h2);
        wait_idle("drop_idle");
`endif
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        req       = 4'b1000;
        req_value = {N{4'h0}};
        @(negedge clk);
        chk("mr_load_gnt", 32'(gnt), 32'h8);
        repeat (3) @(negedge clk);
        chk("mr_in_run", 32'({gnt, busy, ctr_load}), 32'({4'b1000, 1'b1, 1'b0}));
        #2 reset_n = 1'b0;
        #1 chk("mr_async_clear", 32'({gnt, done, busy, ctr_load, ctr_load_data}), 32'd0);
        @(negedge clk);
        chk("mr_no_done", 32'(done), 32'd0);
        reset_n   = 1'b1;
        req       = 4'b1010;
        req_value = {N{4'hF}};
        @(negedge clk);
        chk("mr_regrant", 32'({gnt, ctr_load}), 32'({4'b0010, 1'b1}));
        for (int c = 0; c < 10 && done == '0; c++) @(negedge clk);
        chk("mr_done", 32'(done), 32'h2);
        req = '0;
        wait_idle("mr_idle");
    endtask

    task automatic random_phase(input int ncyc);
        bit            m_busy;
        bit            ab;
        int            m_idx;
        int            m_pos;
        int            m_len;
        int            m_ptr;
        logic [WW-1:0] m_ld;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_done;
        logic          e_busy;
        logic          e_load;
        m_busy = 0; m_idx = 0; m_pos = 0; m_len = 0; m_ptr = 0; m_ld = '0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            // Slot timeline: position 0 = load, 1..m_len = run, m_len+1 = done.
            e_gnt  = (m_busy && m_pos <= m_len) ? ({{(N-1){1'b0}}, 1'b1} << m_idx) : '0;
            e_done = (m_busy && m_pos == m_len + 1) ? ({{(N-1){1'b0}}, 1'b1} << m_idx) : '0;
            e_busy = m_busy;
            e_load = m_busy && m_pos == 0;
            chk("rand_outputs", 32'({gnt, done, busy, ctr_load, ctr_load_data}),
                32'({e_gnt, e_done, e_busy, e_load, m_ld}));
            if ($urandom_range(7) == 0) req = N'($urandom & $urandom);
            req_value = (N*WW)'($urandom);
            if (!m_busy) begin
                if (req != '0) begin
                    m_idx  = rr_ref(req, m_ptr);
                    m_busy = 1;
                    m_pos  = 0;
                    m_ld   = req_value[m_idx*WW +: WW];
                    m_len  = (1 << WW) - int'(m_ld);
                end
            end else begin
                ab = 0;
`ifdef SLOT_ABORT_EN
                ab = (m_pos <= m_len) && !req[m_idx];
`endif
                m_pos++;
                if (ab || m_pos > m_len + 1) begin
                    m_busy = 0;
                    m_ptr  = (m_idx + 1) % N;
                end
            end
        end
        req = '0;
    endtask

    initial begin
        tbl[0] = '{4'b0100, 4'hC, 4'b0100, 4};
        tbl[1] = '{4'b0001, 4'hF, 4'b0001, 1};
        tbl[2] = '{4'b1000, 4'h0, 4'b1000, 16};
        tbl[3] = '{4'b0010, 4'h7, 4'b0010, 9};
        tbl[4] = '{4'b1111, 4'hA, 4'b0001, 6};
        tbl[5] = '{4'b1010, 4'hE, 4'b0010, 2};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_slot(tbl[i].mask, tbl[i].v, tbl[i].exp_gnt, tbl[i].exp_run);
        end

        round_robin();
        drop_or_abort();
        reset_mid_run();
        random_phase(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
